bounded_integrator_mc: RTL

Multi-channel, runtime-configurable moving-sum filter: y[n] = x[n] + y[n-1] - x[n-L] per channel, where L is a window length set at run time. Channels arrive time-interleaved on one AXI-stream-style input. Output is registered with full valid/ready backpressure. Sits in the DSP library as the general moving-sum/boxcar stage ahead of decimators and power/level detectors.

---
 rtl/bounded_integrator_mc.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/bounded_integrator_mc.sv
// ---------------------------------------------------------------------------
// bounded_integrator_mc
//
// Multi-channel moving-sum (boxcar) filter: y[n] = x[n] + y[n-1] - x[n-L]
// for each of NCHAN time-interleaved channels, with the window length L
// chosen at run time (latched from cfg_len on clear).
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   clear       synchronous clear; zeroes state and latches cfg_len
//   cfg_len     window length (0 -> 1, > MAX_SIZE -> MAX_SIZE)
//   i_tdata     signed input sample
//   i_tvalid    input valid
//   i_tlast     marks the beat for channel NCHAN-1
//   i_tready    input ready (~o_tvalid | o_tready)
//   o_tdata     signed moving sum, WIDTH+LW bits
//   o_tchan     channel index of o_tdata
//   o_tlast     high when o_tchan == NCHAN-1
//   o_tvalid    output valid
//   o_tready    output ready
//   o_sync_err  one-cycle pulse when i_tlast disagrees with the channel count
//
// Optional feature: define BOUNDED_INTEGRATOR_WARMUP_EN to suppress outputs
// until each channel's window has been filled once since the last clear.
// ---------------------------------------------------------------------------
module bounded_integrator_mc #(
    parameter int WIDTH    = 16,
    parameter int MAX_SIZE = 32,
    parameter int NCHAN    = 4,
    localparam int LW = $clog2(MAX_SIZE + 1),
    localparam int SW = WIDTH + LW,
    localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [LW-1:0]    cfg_len,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tvalid,
    input  logic             i_tlast,
    output logic             i_tready,
    output logic [SW-1:0]    o_tdata,
    output logic [CW-1:0]    o_tchan,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             o_sync_err
);
    localparam int PW = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
    localparam logic [CW-1:0] LAST_CHAN = CW'(NCHAN - 1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(MAX_SIZE - 1);

    logic [LW-1:0] len_reg;
    logic [PW-1:0] wptr_reg;
    logic [CW-1:0] chan_reg;

    logic accept;
    logic take;
    logic last_chan;
    logic emit;

    assign i_tready  = ~o_tvalid | o_tready;
    assign accept    = i_tvalid & i_tready;
    // clear wins over a coincident beat: the beat is dropped entirely
    assign take      = accept & ~clear;
    assign last_chan = (chan_reg == LAST_CHAN);

    // Window length sanitising applied at latch time
    logic [LW-1:0] len_eff;
    always_comb begin
        len_eff = cfg_len;
        if (cfg_len == '0) begin
            len_eff = LW'(1);
        end else if (cfg_len > LW'(MAX_SIZE)) begin
            len_eff = LW'(MAX_SIZE);
        end
    end

    // Tap that leaves the window: (wptr - L) mod MAX_SIZE. L == MAX_SIZE
    // lands on wptr itself, i.e. the entry about to be overwritten.
    logic [LW:0]   rd_wide;
    logic [PW-1:0] rd_idx;
    always_comb begin
        rd_wide = (LW+1)'(wptr_reg) + (LW+1)'(MAX_SIZE) - (LW+1)'(len_reg);
        if (rd_wide >= (LW+1)'(MAX_SIZE)) begin
            rd_wide = rd_wide - (LW+1)'(MAX_SIZE);
        end
    end
    assign rd_idx = PW'(rd_wide);

    logic signed [SW-1:0] x_ext;
    logic signed [SW-1:0] sum_new;
    logic signed [SW-1:0] sum_arr [NCHAN];
    logic signed [SW-1:0] old_arr [NCHAN];

    assign x_ext   = {{LW{i_tdata[WIDTH-1]}}, i_tdata};
    assign sum_new = sum_arr[chan_reg] + x_ext - old_arr[chan_reg];

    generate
        for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
            // The departing sample is needed in the same cycle as the
            // write, so the delay line is read asynchronously. A per-entry
            // valid bitmap makes clear instant without sweeping the array;
            // never-written entries read back as zero.
            logic [WIDTH-1:0]     mem [MAX_SIZE];
            logic [MAX_SIZE-1:0]  vld_reg;
            logic signed [SW-1:0] sum_reg;
            logic                 wr_en;

            assign wr_en = take && (chan_reg == CW'(gi));

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem[wptr_reg] <= i_tdata;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    vld_reg <= '0;
                    sum_reg <= '0;
                end else if (clear) begin
                    vld_reg <= '0;
                    sum_reg <= '0;
                end else if (wr_en) begin
                    vld_reg[wptr_reg] <= 1'b1;
                    sum_reg           <= sum_new;
                end
            end

            assign old_arr[gi] = vld_reg[rd_idx] ?
                                 {{LW{mem[rd_idx][WIDTH-1]}}, mem[rd_idx]} : '0;
            assign sum_arr[gi] = sum_reg;
        end
    endgenerate

`ifdef BOUNDED_INTEGRATOR_WARMUP_EN
    // Completed frames since clear, saturating at the window length. A
    // channel's sample index equals the frame count at the time it arrives.
    logic [LW-1:0] fill_reg;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_reg <= '0;
        end else if (clear) begin
            fill_reg <= '0;
        end else if (take && last_chan && (fill_reg < len_reg)) begin
            fill_reg <= fill_reg + LW'(1);
        end
    end
    assign emit = ({1'b0, fill_reg} + (LW+1)'(1)) >= {1'b0, len_reg};
`else
    assign emit = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_reg    <= LW'(MAX_SIZE);
            wptr_reg   <= '0;
            chan_reg   <= '0;
            o_tvalid   <= 1'b0;
            o_tdata    <= '0;
            o_tchan    <= '0;
            o_tlast    <= 1'b0;
            o_sync_err <= 1'b0;
        end else if (clear) begin
            len_reg    <= len_eff;
            wptr_reg   <= '0;
            chan_reg   <= '0;
            o_tvalid   <= 1'b0;
            o_sync_err <= 1'b0;
        end else begin
            o_sync_err <= 1'b0;
            if (accept) begin
                o_tvalid   <= emit;
                o_sync_err <= (i_tlast != last_chan);
                if (emit) begin
                    o_tdata <= sum_new;
                    o_tchan <= chan_reg;
                    o_tlast <= last_chan;
                end
                // Wrap after the last channel; an early tlast resyncs to 0
                if (last_chan || i_tlast) begin
                    chan_reg <= '0;
                end else begin
                    chan_reg <= chan_reg + CW'(1);
                end
                if (last_chan) begin
                    wptr_reg <= (wptr_reg == LAST_PTR) ? '0 : wptr_reg + PW'(1);
                end
            end else if (o_tready) begin
                o_tvalid <= 1'b0;
            end
        end
    end

endmodule
